// File: rtl/spi_tx_route_if.sv
// spi_tx_route_if: bus bundle between the MCU side and the slave fan-out of
// spi_tx_route. Carries the select request, the MCU SPI signals, the seven
// per-slave SPI outputs and the routing status.
//   slave  modport : used by spi_tx_route (the router itself)
//   master modport : used by whatever drives the MCU side / observes status
interface spi_tx_route_if;
   logic [6:0] sw_flag;
   logic       mcu_spi_sclk;
   logic       mcu_spi_mosi;
   logic       mcu_spi_cs_n;
   logic [6:0] slave_spi_sclk;
   logic [6:0] slave_spi_mosi;
   logic [6:0] slave_spi_cs_n;
   logic       sel_valid;
   logic [2:0] sel_idx;
   logic       sel_err;

   modport slave (
      input  sw_flag, mcu_spi_sclk, mcu_spi_mosi, mcu_spi_cs_n,
      output slave_spi_sclk, slave_spi_mosi, slave_spi_cs_n,
      output sel_valid, sel_idx, sel_err
   );

   modport master (
      output sw_flag, mcu_spi_sclk, mcu_spi_mosi, mcu_spi_cs_n,
      input  slave_spi_sclk, slave_spi_mosi, slave_spi_cs_n,
      input  sel_valid, sel_idx, sel_err
   );
endinterface

// File: rtl/spi_tx_route.sv
// spi_tx_route: MCU-to-slave half of the 7-slave SPI switch. Forwards the MCU
// SCLK/MOSI/CS_n to exactly one slave chosen by sw_flag. The request is
// synchronised, debounced and checked for one-hot; a new selection is only
// applied while the SPI bus is idle so no slave sees a truncated transfer.
// Ports:
//   clk, rst_n : system clock (>= 4x SCLK), asynchronous active-low reset
//   bus        : spi_tx_route_if.slave
//                in : sw_flag[6:0], mcu_spi_sclk/mosi/cs_n
//                out: slave_spi_sclk/mosi/cs_n[6:0], sel_valid, sel_idx, sel_err

// One output lane: passes the MCU signals through when enabled, otherwise
// parks the slave at its unselected levels. Purely combinational.
module spi_tx_route_lane #(
   parameter logic SCLK_IDLE = 1'b0
) (
   input  logic en,
   input  logic mcu_sclk,
   input  logic mcu_mosi,
   input  logic mcu_cs_n,
   output logic slv_sclk,
   output logic slv_mosi,
   output logic slv_cs_n
);
   assign slv_sclk = en ? mcu_sclk : SCLK_IDLE;
   assign slv_mosi = en ? mcu_mosi : 1'b0;
   assign slv_cs_n = en ? mcu_cs_n : 1'b1;
endmodule

module spi_tx_route #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned GUARD_CYCLES    = 4,
   parameter logic        SCLK_IDLE       = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_tx_route_if.slave   bus
);
   localparam int unsigned NUM_SLV = 7;
   localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]  GUARD   = 8'(GUARD_CYCLES);

   typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

   function automatic logic [2:0] oh2idx(input logic [NUM_SLV-1:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < NUM_SLV; i++)
         if (oh[i]) idx = 3'(i + 1);
      return idx;
   endfunction

   // synchronisers
   logic [NUM_SLV-1:0] sw_s1_q, sw_s_q, sw_prev_q;
   logic               cs_s1_q, cs_s_q;

   // debounce / guard / FSM state
   logic [15:0]        dcnt_q, dcnt_d;
   logic [NUM_SLV-1:0] cand_q, cand_d;
   logic [7:0]         gcnt_q, gcnt_d;
   state_t             state_q, state_d;
   logic [NUM_SLV-1:0] sel_oh_q, sel_oh_d;
   logic [2:0]         sel_idx_q, sel_idx_d;
   logic               sel_valid_q, sel_valid_d;
   logic               sel_err_q, sel_err_d;

   logic               cand_ok;
   logic               bus_idle;

   always_comb begin
      dcnt_d = dcnt_q;
      cand_d = cand_q;
      // any change of the synchronised request restarts the stability window
      if (sw_s_q != sw_prev_q)
         dcnt_d = 16'd0;
      else if (dcnt_q != DEB_MAX)
         dcnt_d = dcnt_q + 16'd1;
      // latch on the cycle the window completes (and keep refreshing while
      // saturated; sw_s is unchanged then, so cand is stable)
      if (dcnt_d == DEB_MAX)
         cand_d = sw_s_q;

      cand_ok   = (cand_q != '0) && ((cand_q & (cand_q - 7'd1)) == '0);
      sel_err_d = (cand_q != '0) && !cand_ok;

      // guard holds at full value while CS is low, so it starts counting
      // down from GUARD_CYCLES on the synchronised rising edge
      if (!cs_s_q)
         gcnt_d = GUARD;
      else if (gcnt_q != 8'd0)
         gcnt_d = gcnt_q - 8'd1;
      else
         gcnt_d = 8'd0;

      // raw CS is included so a falling CS still inside the synchroniser
      // blocks a select change
      bus_idle = cs_s_q && bus.mcu_spi_cs_n && (gcnt_q == 8'd0);

      state_d   = state_q;
      sel_oh_d  = sel_oh_q;
      sel_idx_d = sel_idx_q;
      case (state_q)
         IDLE: begin
            if (cand_ok && bus_idle) begin
               state_d   = ARMED;
               sel_oh_d  = cand_q;
               sel_idx_d = oh2idx(cand_q);
            end
         end
         ARMED: begin
            if (!cs_s_q) begin
               state_d = ACTIVE;
            end else if (bus_idle && (cand_q != sel_oh_q)) begin
               if (cand_ok) begin
                  sel_oh_d  = cand_q;
                  sel_idx_d = oh2idx(cand_q);
               end else begin
                  state_d   = IDLE;
                  sel_oh_d  = '0;
                  sel_idx_d = 3'd0;
               end
            end
         end
         ACTIVE: begin
            // only entered with cs_s low, so cs_s high here is the rising edge
            if (cs_s_q) state_d = ARMED;
         end
         default: begin
            state_d   = IDLE;
            sel_oh_d  = '0;
            sel_idx_d = 3'd0;
         end
      endcase
      sel_valid_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1_q     <= '0;
         sw_s_q      <= '0;
         sw_prev_q   <= '0;
         cs_s1_q     <= 1'b1;
         cs_s_q      <= 1'b1;
         dcnt_q      <= 16'd0;
         cand_q      <= '0;
         gcnt_q      <= 8'd0;
         state_q     <= IDLE;
         sel_oh_q    <= '0;
         sel_idx_q   <= 3'd0;
         sel_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         sw_s1_q     <= bus.sw_flag;
         sw_s_q      <= sw_s1_q;
         sw_prev_q   <= sw_s_q;
         cs_s1_q     <= bus.mcu_spi_cs_n;
         cs_s_q      <= cs_s1_q;
         dcnt_q      <= dcnt_d;
         cand_q      <= cand_d;
         gcnt_q      <= gcnt_d;
         state_q     <= state_d;
         sel_oh_q    <= sel_oh_d;
         sel_idx_q   <= sel_idx_d;
         sel_valid_q <= sel_valid_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // per-slave fan-out
   logic [NUM_SLV-1:0] lane_sclk, lane_mosi, lane_cs_n;

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_lane
      spi_tx_route_lane #(.SCLK_IDLE(SCLK_IDLE)) u_lane (
         .en       (sel_valid_q && sel_oh_q[g]),
         .mcu_sclk (bus.mcu_spi_sclk),
         .mcu_mosi (bus.mcu_spi_mosi),
         .mcu_cs_n (bus.mcu_spi_cs_n),
         .slv_sclk (lane_sclk[g]),
         .slv_mosi (lane_mosi[g]),
         .slv_cs_n (lane_cs_n[g])
      );
   end

   assign bus.slave_spi_sclk = lane_sclk;
   assign bus.slave_spi_mosi = lane_mosi;
   assign bus.slave_spi_cs_n = lane_cs_n;
   assign bus.sel_valid      = sel_valid_q;
   assign bus.sel_idx        = sel_idx_q;
   assign bus.sel_err        = sel_err_q;
endmodule

// File: tb/tb_spi_tx_route.sv
// Self-checking bench for spi_tx_route: directed scenarios followed by random
// select/transfer rounds. A per-slave capture monitor rebuilds the bytes and
// CS activity each slave observes; expectations come from the select rules.
module tb_spi_tx_route;
   localparam int D = 16;
   localparam int G = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   spi_tx_route_if bus ();

   spi_tx_route #(.DEBOUNCE_CYCLES(D), .GUARD_CYCLES(G), .SCLK_IDLE(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // capture monitor: sample at posedge, inputs change on negedge
   logic [6:0] p_sclk, p_cs;
   logic [7:0] shreg [7];
   int         bits  [7];
   int         falls [7];

   always @(posedge clk) begin
      p_sclk <= bus.slave_spi_sclk;
      p_cs   <= bus.slave_spi_cs_n;
      for (int i = 0; i < 7; i++) begin
         if (p_sclk[i] === 1'b0 && bus.slave_spi_sclk[i] === 1'b1 && bus.slave_spi_cs_n[i] === 1'b0) begin
            shreg[i] <= {shreg[i][6:0], bus.slave_spi_mosi[i]};
            bits[i]  <= bits[i] + 1;
         end
         if (p_cs[i] === 1'b1 && bus.slave_spi_cs_n[i] === 1'b0)
            falls[i] <= falls[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_lo();
      @(negedge clk);
      bus.mcu_spi_cs_n = 1'b0;
      clks(2);
   endtask

   task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         bus.mcu_spi_mosi = b[i];
         bus.mcu_spi_sclk = 1'b0;
         clks(2);
         bus.mcu_spi_sclk = 1'b1;
         clks(2);
      end
   endtask

   task automatic cs_hi();
      bus.mcu_spi_sclk = 1'b0;
      clks(2);
      bus.mcu_spi_cs_n = 1'b1;
      bus.mcu_spi_mosi = 1'b0;
   endtask

   // send one byte; k = 1..7 is the slave expected to receive it, 0 = none
   task automatic xfer(input string tag, input int k, input logic [7:0] b);
      int b0 [7];
      int f0 [7];
      for (int i = 0; i < 7; i++) begin b0[i] = bits[i]; f0[i] = falls[i]; end
      cs_lo();
      send_bits(b, 7, 0);
      cs_hi();
      clks(2);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("%s_bits_s%0d", tag, i + 1), 32'(bits[i] - b0[i]), (i == k - 1) ? 32'd8 : 32'd0);
         chk($sformatf("%s_csfall_s%0d", tag, i + 1), 32'(falls[i] - f0[i]), (i == k - 1) ? 32'd1 : 32'd0);
      end
      if (k != 0) chk($sformatf("%s_data", tag), 32'(shreg[k-1]), 32'(b));
   endtask

   // reference: expected status for a request held long enough with bus idle
   function automatic int ref_idx(input logic [6:0] sw);
      if ($countones(sw) != 1) return 0;
      for (int i = 0; i < 7; i++) if (sw[i]) return i + 1;
      return 0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int f1;
      logic [6:0] sw;
      logic [7:0] data;
      int exp_idx;

      rst_n = 1'b0;
      bus.sw_flag = 7'd0;
      bus.mcu_spi_sclk = 1'b0;
      bus.mcu_spi_mosi = 1'b0;
      bus.mcu_spi_cs_n = 1'b1;
      clks(3);
      chk("rst_cs_n", 32'(bus.slave_spi_cs_n), 32'h7F);
      chk("rst_sclk", 32'(bus.slave_spi_sclk), 32'h00);
      chk("rst_mosi", 32'(bus.slave_spi_mosi), 32'h00);
      chk("rst_valid", 32'(bus.sel_valid), 32'd0);
      chk("rst_idx", 32'(bus.sel_idx), 32'd0);
      chk("rst_err", 32'(bus.sel_err), 32'd0);
      rst_n = 1'b1;

      // select slave 3: routed exactly 2 + D + 1 clocks after the request
      bus.sw_flag = 7'b0000100;
      repeat (2 + D) @(posedge clk);
      #1 chk("t1_not_yet", 32'(bus.sel_valid), 32'd0);
      @(posedge clk);
      #1 chk("t1_valid", 32'(bus.sel_valid), 32'd1);
      chk("t1_idx", 32'(bus.sel_idx), 32'd3);
      clks(2);
      xfer("t1", 3, 8'hA5);

      // request slave 7 in the middle of a byte to slave 3
      cs_lo();
      send_bits(8'h3C, 7, 4);
      bus.sw_flag = 7'b1000000;
      clks(D + 8);
      chk("t2_locked", 32'(bus.sel_idx), 32'd3);
      send_bits(8'h3C, 3, 0);
      bus.mcu_spi_sclk = 1'b0;
      clks(2);
      bus.mcu_spi_cs_n = 1'b1;
      repeat (2 + G) @(posedge clk);
      #1 chk("t2_guard_hold", 32'(bus.sel_idx), 32'd3);
      @(posedge clk);
      #1 chk("t2_switched", 32'(bus.sel_idx), 32'd7);
      chk("t2_s3_byte", 32'(shreg[2]), 32'h3C);
      clks(2);
      xfer("t2", 7, 8'h5A);

      // short glitch to slave 1 must be filtered out
      f1 = falls[0];
      @(negedge clk);
      bus.sw_flag = 7'b0000001;
      clks(5);
      bus.sw_flag = 7'b1000000;
      clks(D + 10);
      chk("t3_idx", 32'(bus.sel_idx), 32'd7);
      chk("t3_s1_nofall", 32'(falls[0] - f1), 32'd0);

      // non one-hot request drops the route and flags an error
      bus.sw_flag = 7'b0011000;
      clks(D + 6);
      chk("t4_err", 32'(bus.sel_err), 32'd1);
      chk("t4_valid", 32'(bus.sel_valid), 32'd0);
      chk("t4_idx", 32'(bus.sel_idx), 32'd0);
      chk("t4_cs_n", 32'(bus.slave_spi_cs_n), 32'h7F);
      bus.sw_flag = 7'b0010000;
      clks(D + 6);
      chk("t4_err_clr", 32'(bus.sel_err), 32'd0);
      chk("t4_idx5", 32'(bus.sel_idx), 32'd5);

      // all-zero request returns to no route
      bus.sw_flag = 7'd0;
      clks(D + 6);
      chk("t5_zero_valid", 32'(bus.sel_valid), 32'd0);
      chk("t5_zero_err", 32'(bus.sel_err), 32'd0);

      // select debounces while the MCU already holds CS low
      bus.mcu_spi_cs_n = 1'b0;
      bus.sw_flag = 7'b0000010;
      clks(D + 10);
      chk("t5_busy_valid", 32'(bus.sel_valid), 32'd0);
      chk("t5_busy_cs_n", 32'(bus.slave_spi_cs_n), 32'h7F);
      bus.mcu_spi_cs_n = 1'b1;
      repeat (2 + G) @(posedge clk);
      #1 chk("t5_guard_hold", 32'(bus.sel_valid), 32'd0);
      @(posedge clk);
      #1 chk("t5_armed", 32'(bus.sel_valid), 32'd1);
      chk("t5_idx", 32'(bus.sel_idx), 32'd2);

      // asynchronous reset in the middle of a transfer to slave 2
      cs_lo();
      send_bits(8'hC3, 7, 4);
      chk("t6_cs_low", 32'(bus.slave_spi_cs_n[1]), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("t6_async_cs_n", 32'(bus.slave_spi_cs_n), 32'h7F);
      chk("t6_async_sclk", 32'(bus.slave_spi_sclk), 32'h00);
      chk("t6_async_mosi", 32'(bus.slave_spi_mosi), 32'h00);
      chk("t6_async_valid", 32'(bus.sel_valid), 32'd0);
      chk("t6_async_idx", 32'(bus.sel_idx), 32'd0);
      clks(2);
      rst_n = 1'b1;
      send_bits(8'hC3, 3, 0);
      clks(D + 6);
      chk("t6_wait_bus", 32'(bus.sel_valid), 32'd0);
      cs_hi();
      clks(2 + G + 3);
      chk("t6_rearmed", 32'(bus.sel_valid), 32'd1);
      chk("t6_idx", 32'(bus.sel_idx), 32'd2);

      // random select/transfer rounds
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 2) != 0) sw = 7'(1 << $urandom_range(0, 6));
         else sw = 7'($urandom);
         data = 8'($urandom);
         exp_idx = ref_idx(sw);
         @(negedge clk);
         bus.sw_flag = sw;
         clks(D + 10);
         chk($sformatf("r%0d_valid", r), 32'(bus.sel_valid), (exp_idx != 0) ? 32'd1 : 32'd0);
         chk($sformatf("r%0d_idx", r), 32'(bus.sel_idx), 32'(exp_idx));
         chk($sformatf("r%0d_err", r), 32'(bus.sel_err), (sw != 0 && exp_idx == 0) ? 32'd1 : 32'd0);
         xfer($sformatf("r%0d", r), exp_idx, data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_tx_route.md
Name: spi_tx_route

Overview:
- MCU-to-slave half of the 7-slave SPI switch. Routes the MCU's SCLK, MOSI and CS_n to exactly one of seven slave ports. The slave is chosen by the sw_flag select inputs.
- Select changes are synchronised, debounced, checked for one-hot, and applied only while the bus is idle, so no slave ever sees a truncated transaction.
- Companion to the MISO return mux. Both blocks take the same sw_flag inputs.

Parameters:
- DEBOUNCE_CYCLES, 16, number of clk cycles a synchronised sw_flag pattern must stay stable before it becomes the candidate select (1..65535).
- GUARD_CYCLES, 4, idle clk cycles required after CS_n rises before the select may change (0..255).
- SCLK_IDLE, 1'b0, level driven on SCLK of every unselected slave (CPOL).

Ports:
- clk  in  1  system clock, at least 4x the SPI SCLK rate
- rst_n  in  1  asynchronous active-low reset
- sw_flag  in  7  select request; bit i selects slave i+1; asynchronous
- mcu_spi_sclk  in  1  MCU SPI clock
- mcu_spi_mosi  in  1  MCU SPI data out
- mcu_spi_cs_n  in  1  MCU chip select, active low
- slave_spi_sclk  out  7  per-slave SCLK, bit i = slave i+1
- slave_spi_mosi  out  7  per-slave MOSI
- slave_spi_cs_n  out  7  per-slave CS_n
- sel_valid  out  1  a slave is currently routed
- sel_idx  out  3  routed slave number 1..7; 0 when none
- sel_err  out  1  current debounced request is non-zero and not one-hot

Behaviour:
- Reset (asynchronous, immediate):
  - all slave_spi_cs_n = 7'h7F; slave_spi_sclk = {7{SCLK_IDLE}}; slave_spi_mosi = 0
  - sel_valid = 0, sel_idx = 0, sel_err = 0
  - FSM = IDLE; debounce counter, guard counter and synchronisers cleared (sw sync to 0, CS sync to 1)
- Synchronisation:
  - sw_flag passes through a 2-flop synchroniser (sw_s).
  - mcu_spi_cs_n passes through a 2-flop synchroniser (cs_s).
  - SCLK and MOSI are never registered.
- Debounce:
  - A counter resets to 0 whenever sw_s differs from its previous-cycle value.
  - When the counter reaches DEBOUNCE_CYCLES-1, sw_s is latched as cand and the counter saturates.
  - cand_ok = cand is one-hot. sel_err = (cand != 0) && !cand_ok, registered.
- bus_idle = cs_s && mcu_spi_cs_n && (guard counter == 0). Both the synchronised and the raw CS must be high, which closes the synchroniser race.
- Guard counter:
  - loads GUARD_CYCLES on a cs_s 0->1 edge, then decrements to 0.
  - reloads if CS falls again before reaching 0.
- FSM states:
  - IDLE: no slave routed; all outputs at unselected levels. If cand_ok && bus_idle: latch sel = cand, go to ARMED.
  - ARMED: route sel; cs_s==1.
    - cs_s==0 -> ACTIVE.
    - bus_idle && cand != sel: if cand_ok, load the new sel (stay ARMED, no IDLE cycle); otherwise go to IDLE.
  - ACTIVE: route sel and lock it; cand changes are ignored. cs_s 0->1 -> ARMED, with the guard counter loaded.
  - Select changes are deferred, never dropped: the latest cand is evaluated once bus_idle holds.
- Routing (combinational from registered sel/state):
  - selected slave k: slave_spi_sclk[k] = mcu_spi_sclk, slave_spi_mosi[k] = mcu_spi_mosi, slave_spi_cs_n[k] = mcu_spi_cs_n
  - all others at unselected levels
  - sel_valid = state != IDLE; sel_idx = k+1 when valid, else 0.
- Entering IDLE while the MCU holds CS low is impossible. Leaving IDLE requires bus_idle, so a transaction already in progress at select time is not forwarded.
- Reset asserted mid-transaction: the slave's CS_n goes high asynchronously. After release the FSM restarts in IDLE and waits for bus_idle.
- All sw_flag == 0: cand = 0, sel_err = 0. From ARMED with bus_idle -> IDLE.

Test Plan:
- Reset, sw_flag=7'b0000100 held 30 clks, CS_n high -> after 2 + DEBOUNCE_CYCLES + 1 clks: sel_valid=1, sel_idx=3; an 8-bit MOSI pattern 0xA5 appears only on slave_spi_mosi[2]; the other six CS_n stay 1.
- Slave 3 active (CS_n low), sw_flag changed to 7'b1000000 mid-byte -> sel_idx stays 3 until CS_n rises + sync + GUARD_CYCLES, then becomes 7; slave 3 sees the complete byte; the next transfer goes to slave 7 only.
- sw_flag glitch to 7'b0000001 for 5 clks (< DEBOUNCE_CYCLES), then back -> sel_idx unchanged, no CS_n toggle on slave 1.
- sw_flag=7'b0011000 stable -> sel_err=1; with bus idle, sel_valid=0, sel_idx=0, all CS_n = 7'h7F. Then sw_flag=7'b0010000 -> sel_err=0, sel_idx=5.
- MCU CS_n already low when a valid select debounces -> stay IDLE, slave CS_n held high; after CS_n high for GUARD_CYCLES -> ARMED.
- rst_n pulsed low mid-transaction to slave 2 -> slave_spi_cs_n[1]=1 in the same cycle without a clk edge; all outputs at reset values; re-arms only after select is debounced and the bus is idle.
